// File: rtl/rbi_ring_inject_node_if.sv
// Ring slot, local request and local response signals of one ring inject node.
// The node itself takes the slave view; the environment takes the master view.
interface rbi_ring_inject_node_if;
  logic [15:0]  ringSeqIn;
  logic [15:0]  ringOpmIn;
  logic [47:0]  ringAddrIn;
  logic [127:0] ringDataIn;
  logic [15:0]  ringSeqOut;
  logic [15:0]  ringOpmOut;
  logic [47:0]  ringAddrOut;
  logic [127:0] ringDataOut;
  logic [7:0]   unitNodeId;
  logic         reqValid;
  logic         reqReady;
  logic [7:0]   reqSeqLo;
  logic [15:0]  reqOpm;
  logic [47:0]  reqAddr;
  logic [127:0] reqData;
  logic         rspValid;
  logic         rspReady;
  logic [15:0]  rspSeq;
  logic [15:0]  rspOpm;
  logic [47:0]  rspAddr;
  logic [127:0] rspData;
  logic         starveFlag;

  modport slave (
    input  ringSeqIn, ringOpmIn, ringAddrIn, ringDataIn,
    input  unitNodeId,
    input  reqValid, reqSeqLo, reqOpm, reqAddr, reqData,
    input  rspReady,
    output ringSeqOut, ringOpmOut, ringAddrOut, ringDataOut,
    output reqReady,
    output rspValid, rspSeq, rspOpm, rspAddr, rspData,
    output starveFlag
  );

  modport master (
    output ringSeqIn, ringOpmIn, ringAddrIn, ringDataIn,
    output unitNodeId,
    output reqValid, reqSeqLo, reqOpm, reqAddr, reqData,
    output rspReady,
    input  ringSeqOut, ringOpmOut, ringAddrOut, ringDataOut,
    input  reqReady,
    input  rspValid, rspSeq, rspOpm, rspAddr, rspData,
    input  starveFlag
  );
endinterface

// File: rtl/rbi_ring_inject_node.sv
// Ring node upstream of the L2 segment: one register stage per slot, captures own responses,
// injects queued local requests into empty or freed slots, flags prolonged injection starvation.
module rbi_ring_inject_node #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_LIM = 64
) (
  input logic                   clock,
  input logic                   reset,
  rbi_ring_inject_node_if.slave bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [7:0]   seq_lo;
    logic [15:0]  opm;
    logic [47:0]  addr;
    logic [127:0] data;
  } req_t;

  typedef struct packed {
    logic [15:0]  seq;
    logic [15:0]  opm;
    logic [47:0]  addr;
    logic [127:0] data;
  } msg_t;

  req_t            mem_q [DEPTH];
  req_t            req_in;
  req_t            head;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ready_q;

  msg_t            ring_in;
  msg_t            ring_q, ring_d;
  msg_t            rsp_q, rsp_d;
  logic            rsp_valid_q, rsp_valid_d;

  logic [7:0]      starve_q, starve_d;
  logic            starve_flag_q;

  logic            own_rsp;
  logic            empty_slot;
  logic            capture;
  logic            slot_free;
  logic            queue_nonempty;
  logic            inject;
  logic            push;

  assign ring_in = {bus.ringSeqIn, bus.ringOpmIn, bus.ringAddrIn, bus.ringDataIn};
  assign req_in  = {bus.reqSeqLo, bus.reqOpm, bus.reqAddr, bus.reqData};
  assign head    = mem_q[rd_ptr_q];

  // Slot classification and per-cycle priority: capture, forward, inject, pass through.
  always_comb begin
    own_rsp        = (bus.ringOpmIn[7:6] == 2'b01) && (bus.ringOpmIn[7:0] != 8'h00) &&
                     (bus.ringSeqIn[15:8] == bus.unitNodeId);
    empty_slot     = (bus.ringOpmIn[7:0] == 8'h00);
    capture        = own_rsp && (!rsp_valid_q || bus.rspReady);
    slot_free      = empty_slot || capture;
    queue_nonempty = (count_q != '0);
    inject         = slot_free && queue_nonempty;
    push           = bus.reqValid && ready_q;
  end

  always_comb begin
    ring_d = ring_in;
    if (inject) begin
      ring_d = {bus.unitNodeId, head.seq_lo, head.opm, head.addr, head.data};
    end else if (capture) begin
      ring_d = '0;
    end
  end

  always_comb begin
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    if (capture) begin
      rsp_d       = ring_in;
      rsp_valid_d = 1'b1;
    end else if (rsp_valid_q && bus.rspReady) begin
      rsp_d       = '0;
      rsp_valid_d = 1'b0;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (inject) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, inject})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    starve_d = '0;
    if (queue_nonempty && !inject) begin
      starve_d = (starve_q == 8'hFF) ? starve_q : starve_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ring_q        <= '0;
      rsp_q         <= '0;
      rsp_valid_q   <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ready_q       <= 1'b0;
      starve_q      <= '0;
      starve_flag_q <= 1'b0;
    end else begin
      ring_q        <= ring_d;
      rsp_q         <= rsp_d;
      rsp_valid_q   <= rsp_valid_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      // Ready follows the registered count, so a full queue refuses even while it dequeues.
      ready_q       <= (count_d < CntW'(DEPTH));
      starve_q      <= starve_d;
      starve_flag_q <= (starve_d >= 8'(STARVE_LIM));
    end
  end

  // Storage needs no reset: entries are only read once the count says they were written.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= req_in;
    end
  end

  assign bus.ringSeqOut  = ring_q.seq;
  assign bus.ringOpmOut  = ring_q.opm;
  assign bus.ringAddrOut = ring_q.addr;
  assign bus.ringDataOut = ring_q.data;
  assign bus.reqReady    = ready_q;
  assign bus.rspValid    = rsp_valid_q;
  assign bus.rspSeq      = rsp_q.seq;
  assign bus.rspOpm      = rsp_q.opm;
  assign bus.rspAddr     = rsp_q.addr;
  assign bus.rspData     = rsp_q.data;
  assign bus.starveFlag  = starve_flag_q;

endmodule
